// File: rtl/coherent_dcache.sv
`default_nettype none
// ----------------------------------------------------------------------------
// coherent_dcache : direct-mapped MSI L1 data cache, 2-word blocks, snoopable
// Revision 1.0
// ----------------------------------------------------------------------------
module coherent_dcache #(
  parameter int SETS   = 8,
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic [ADDR_W-1:0] dmemaddr,
  input  logic [31:0]       dmemstore,
  output logic              dhit,
  output logic [31:0]       dmemload,
  output logic              dREN,
  output logic              dWEN,
  output logic [ADDR_W-1:0] daddr,
  output logic [31:0]       dstore,
  input  logic [31:0]       dload,
  input  logic              dwait,
  output logic              cctrans,
  output logic              ccwrite,
  input  logic              ccwait,
  input  logic              ccinv,
  input  logic [ADDR_W-1:0] ccsnoopaddr,
  output logic              have
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - 3;

  typedef enum logic [2:0] {IDLE, WB1, WB2, RD1, RD2} fsm_t;
  typedef enum logic [1:0] {LS_I, LS_S, LS_M} line_t;

  fsm_t             state_q, state_d;
  line_t            lst_q  [SETS];
  line_t            lst_d  [SETS];
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [TAG_W-1:0] tag_d  [SETS];
  logic [31:0]      data_q [SETS][2];
  logic [31:0]      data_d [SETS][2];

  logic [TAG_W-1:0] req_tag, snp_tag;
  logic [IDX_W-1:0] req_idx, snp_idx;
  logic             req_word, snp_word;
  logic             req_tag_hit, cpu_hit, victim_dirty, snp_match;
  logic             unused_low_bits;

  assign req_tag  = dmemaddr[ADDR_W-1:IDX_W+3];
  assign req_idx  = dmemaddr[IDX_W+2:3];
  assign req_word = dmemaddr[2];
  assign snp_tag  = ccsnoopaddr[ADDR_W-1:IDX_W+3];
  assign snp_idx  = ccsnoopaddr[IDX_W+2:3];
  assign snp_word = ccsnoopaddr[2];
  assign unused_low_bits = ^{dmemaddr[1:0], ccsnoopaddr[1:0]};

  assign req_tag_hit  = (lst_q[req_idx] != LS_I) && (tag_q[req_idx] == req_tag);
  assign cpu_hit      = (state_q == IDLE) && !ccwait &&
                        ((dmemREN && req_tag_hit) ||
                         (dmemWEN && req_tag_hit && (lst_q[req_idx] == LS_M)));
  // Re-evaluated every IDLE cycle so a snoop that downgrades the victim skips the write-back
  assign victim_dirty = (lst_q[req_idx] == LS_M) && (tag_q[req_idx] != req_tag);
  assign snp_match    = (lst_q[snp_idx] != LS_I) && (tag_q[snp_idx] == snp_tag);
  assign have         = (tag_q[snp_idx] == snp_tag) && (lst_q[snp_idx] == LS_M);

  always_comb begin
    dhit     = cpu_hit;
    dmemload = cpu_hit ? data_q[req_idx][req_word] : '0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    cctrans  = 1'b0;
    ccwrite  = 1'b0;
    daddr    = '0;
    dstore   = '0;
    if (ccwait) begin
      dstore = data_q[snp_idx][snp_word];
    end else begin
      case (state_q)
        WB1, WB2: begin
          dWEN   = 1'b1;
          daddr  = {tag_q[req_idx], req_idx, (state_q == WB2), 2'b00};
          dstore = data_q[req_idx][state_q == WB2];
        end
        RD1, RD2: begin
          dREN    = 1'b1;
          cctrans = 1'b1;
          ccwrite = dmemWEN;
          daddr   = {req_tag, req_idx, (state_q == RD2), 2'b00};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    lst_d   = lst_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (ccwait) begin
      if (snp_match) begin
        if (ccinv)                           lst_d[snp_idx] = LS_I;
        else if (lst_q[snp_idx] == LS_M)     lst_d[snp_idx] = LS_S;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_hit) begin
            if (dmemWEN) data_d[req_idx][req_word] = dmemstore;
          end else if (dmemREN || dmemWEN) begin
            state_d = victim_dirty ? WB1 : RD1;
          end
        end
        WB1: if (!dwait) state_d = WB2;
        WB2: begin
          if (!dwait) begin
            lst_d[req_idx] = LS_I;
            state_d        = RD1;
          end
        end
        RD1: begin
          if (!dwait) begin
            data_d[req_idx][0] = dload;
            state_d            = RD2;
          end
        end
        RD2: begin
          if (!dwait) begin
            data_d[req_idx][1] = dload;
            tag_d[req_idx]     = req_tag;
            lst_d[req_idx]     = dmemWEN ? LS_M : LS_S;
            state_d            = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      for (int i = 0; i < SETS; i++) begin
        lst_q[i]     <= LS_I;
        tag_q[i]     <= '0;
        data_q[i][0] <= '0;
        data_q[i][1] <= '0;
      end
    end else begin
      state_q <= state_d;
      lst_q   <= lst_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/coherent_dcache.md
Name: coherent_dcache

Overview:
- Per-CPU L1 data cache: the requester/snoop-responder end of the two-CPU MSI bus arbitrated by the memory controller.
- Serves CPU loads and stores, issues fills (BusRd/BusRdX) and dirty evictions, and answers controller snoops.
- Snoop answers: supplies M data and performs M->S / ->I state changes.
- Sits between the datapath and the controller's per-CPU cache-control port.

Parameters:
SETS, 8, number of direct-mapped sets; 2 words (8 bytes) per block; index width clog2(SETS)=3
ADDR_W, 32, address width; tag = addr[31:6], index = addr[5:3], word = addr[2], addr[1:0] ignored

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
dmemREN  in  1  CPU load request
dmemWEN  in  1  CPU store request (REN/WEN never both high)
dmemaddr  in  32  CPU word address
dmemstore  in  32  CPU store data
dhit  out  1  one-cycle request-complete pulse
dmemload  out  32  load data, valid with dhit
dREN  out  1  bus read (fill)
dWEN  out  1  bus write (eviction)
daddr  out  32  bus word address
dstore  out  32  eviction data or snoop-response data
dload  in  32  fill data
dwait  in  1  low = current bus word done
cctrans  out  1  coherence transaction; high with dREN
ccwrite  out  1  fill is for ownership (BusRdX)
ccwait  in  1  controller is snooping this cache
ccinv  in  1  invalidate snooped block
ccsnoopaddr  in  32  snooped word address
have  out  1  combinational: snoop tag hit on valid-M line

Behaviour:
Reset and line states:
- Reset (async, any time, including mid-transaction): every line to I, tags/data 0, FSM to IDLE, all outputs 0 except have (combinational, 0 since all lines I).
- Line states: I, S, M.

FSM states: IDLE, WB1, WB2, RD1, RD2.

IDLE:
- Read hit (S or M), or write hit on M: dhit=1 same cycle, dmemload = selected word. A write updates the word at the clock edge.
- Write to S, or any miss: if the victim is M go to WB1, else go to RD1. No dhit.
- The CPU holds its request until dhit.

WB1/WB2 (eviction):
- dWEN=1; daddr = {victim tag, index, word 0 (WB1) / word 1 (WB2), 00}; dstore = that word.
- Advance on dwait=0; WB2 -> RD1 with victim state = I.

RD1/RD2 (fill):
- dREN=1, cctrans=1; ccwrite = (CPU request is a store); daddr = {req tag, index, word 0 (RD1) / word 1 (RD2), 00}.
- On dwait=0 write dload into that word; RD2 -> IDLE.
- On the RD2 done edge: tag written; state = M if ccwrite, else S.
- Back in IDLE the request hits and dhit fires; a store hits on M. Miss latency = controller latency + 1 cycle.

Snoop (priority over everything):
- While ccwait=1, in any FSM state, the FSM holds: dREN=dWEN=cctrans=ccwrite=0, dwait is ignored, no CPU dhit.
- dstore = data[snoop index][ccsnoopaddr[2]] (controller steps words 0/1 via ccsnoopaddr).
- have = (tag[snoop index]==ccsnoopaddr[31:6]) && state==M, combinational, same cycle.
- Each edge with ccwait=1, snoop tag match and state != I:
  - ccinv=1: line -> I. Data is retained so write-back words can still be driven.
  - ccinv=0 and state M: line -> S.
- When ccwait drops, the FSM resumes, re-asserting its pending request and reissuing the current word.

Tag and index rules:
- Snoop to a non-matching tag: no state change, have=0.
- Snoop invalidating the very index being filled: the fill overwrites it normally.
- Snoop hitting a line that is the pending victim: if it became I or S before WB1, the eviction is skipped (go to RD1). This is re-evaluated each IDLE cycle.

Same-index swap:
- A CPU access to the same index with a different tag evicts and replaces.
- No wrap/overflow concerns; word select is addr[2] only.

Test Plan:
- Reset then load 0x0000_0040 -> RD1/RD2 with cctrans=1, ccwrite=0, daddr 0x40 then 0x44. Given dload 0xAAAA_0001/0xAAAA_0002, dhit returns 0xAAAA_0001 and the line is S.
- Store 0xDEAD_BEEF to 0x44 with the line in S -> BusRdX fill (ccwrite=1). Line ends M, word1 = 0xDEAD_BEEF, one dhit.
- Load 0x0000_0080 (same index 0, line M) -> WB1/WB2 with dWEN, daddr 0x40/0x44, dstore 0xAAAA_0001/0xDEAD_BEEF, then a fill of 0x80.
- With line 0x40 in M, ccwait=1, ccinv=0, ccsnoopaddr 0x40 then 0x44 -> have=1, dstore tracks words, line -> S, no dREN/dWEN while ccwait.
- ccwait=1, ccinv=1 on a matching S line -> line I, have=0; next CPU load to it misses. Snoop of a non-matching tag leaves the line unchanged.
- Assert nRST low during RD2 -> all outputs 0 immediately; after release, the prior address misses.
